// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Memory-side responder for the CPU external bus. Each accepted CPU bus
// cycle becomes one req/ack transaction on the memory port while cpu_rdy
// stalls the CPU. Reads of the vector window 0xFFFA-0xFFFF are answered
// locally from parameters; writes to that window are dropped. A wait-state
// counter aborts a transaction that is never acknowledged.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_addr_high/low CPU address (ABH/ABL)
//   cpu_data_out      CPU write data (DOR)
//   cpu_rw            1 = read, 0 = write
//   cpu_req           CPU presents a bus cycle this clock
//   cpu_data_in       read data to the datapath, holds last value
//   cpu_rdy           1 = CPU may proceed, 0 = stall
//   mem_addr/wdata/we captured transaction, stable while mem_req is high
//   mem_req           transaction request, held until ack or abort
//   mem_ack/mem_rdata completion and read data (same cycle)
//   bus_error         one-cycle pulse on timeout abort
module cpu_bus_responder #(
  parameter logic [15:0] NMI_VECTOR      = 16'hFFF0,
  parameter logic [15:0] RESET_VECTOR    = 16'h8000,
  parameter logic [15:0] IRQ_VECTOR      = 16'hFFF8,
  parameter bit          VECTOR_OVERRIDE = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpu_addr_high,
  input  logic [7:0]  cpu_addr_low,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_t;

  // The counter holds the number of ack-less cycles already spent, so the
  // abort edge is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cpu_data_in_q;
  logic        cpu_rdy_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic        mem_req_q;
  logic        bus_error_q;

  logic        in_vec_win;
  logic [7:0]  vec_byte;

  assign in_vec_win = VECTOR_OVERRIDE && (cpu_addr_high == 8'hFF) &&
                      (cpu_addr_low >= 8'hFA);

  always_comb begin
    vec_byte = 8'h00;
    unique case (cpu_addr_low[2:0])
      3'b010:  vec_byte = NMI_VECTOR[7:0];
      3'b011:  vec_byte = NMI_VECTOR[15:8];
      3'b100:  vec_byte = RESET_VECTOR[7:0];
      3'b101:  vec_byte = RESET_VECTOR[15:8];
      3'b110:  vec_byte = IRQ_VECTOR[7:0];
      3'b111:  vec_byte = IRQ_VECTOR[15:8];
      default: vec_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'h00;
      cpu_data_in_q <= 8'h00;
      cpu_rdy_q     <= 1'b1;
      mem_addr_q    <= 16'h0000;
      mem_wdata_q   <= 8'h00;
      mem_we_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      bus_error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (in_vec_win) begin
              // Vector writes are silently dropped.
              if (cpu_rw) cpu_data_in_q <= vec_byte;
            end else begin
              mem_addr_q  <= {cpu_addr_high, cpu_addr_low};
              mem_wdata_q <= cpu_data_out;
              mem_we_q    <= ~cpu_rw;
              mem_req_q   <= 1'b1;
              cpu_rdy_q   <= 1'b0;
              cnt_q       <= 8'h00;
              state_q     <= cpu_rw ? READ_WAIT : WRITE_WAIT;
            end
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          // Ack takes priority over a timeout on the same edge.
          if (mem_ack) begin
            if (state_q == READ_WAIT) cpu_data_in_q <= mem_rdata;
            mem_req_q <= 1'b0;
            cpu_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            if (state_q == READ_WAIT) cpu_data_in_q <= 8'hFF;
            mem_req_q   <= 1'b0;
            cpu_rdy_q   <= 1'b1;
            bus_error_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_data_in = cpu_data_in_q;
  assign cpu_rdy     = cpu_rdy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_req     = mem_req_q;
  assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_addr_high, cpu_addr_low, cpu_data_out;
  logic        cpu_rw, cpu_req;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req, mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_error;

  int passed = 0;
  int total  = 0;

  cpu_bus_responder #(
    .NMI_VECTOR     (16'hFFF0),
    .RESET_VECTOR   (16'h8000),
    .IRQ_VECTOR     (16'hFFF8),
    .VECTOR_OVERRIDE(1'b1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr_high(cpu_addr_high),
    .cpu_addr_low (cpu_addr_low),
    .cpu_data_out (cpu_data_out),
    .cpu_rw       (cpu_rw),
    .cpu_req      (cpu_req),
    .cpu_data_in  (cpu_data_in),
    .cpu_rdy      (cpu_rdy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_addr_high = a[15:8];
    cpu_addr_low  = a[7:0];
    cpu_rw        = rw;
    cpu_data_out  = d;
    cpu_req       = 1'b1;
    tick();
    cpu_req       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({cpu_rdy, mem_req, bus_error, mem_we} !== 4'b1000) $display("FAIL reset_ctrl rdy/req/err/we got %b want 1000", {cpu_rdy, mem_req, bus_error, mem_we});
    else passed++;
    total++;
    if (cpu_data_in !== 8'h00) $display("FAIL reset_data got %h want 00", cpu_data_in);
    else passed++;
    total++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) $display("FAIL reset_mem addr %h wdata %h want 0000 00", mem_addr, mem_wdata);
    else passed++;
  endtask

  task automatic test_vector_read();
    logic [15:0] addrs [4] = '{16'hFFFC, 16'hFFFD, 16'hFFFA, 16'hFFFF};
    logic [7:0]  exp   [4] = '{8'h00, 8'h80, 8'hF0, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      issue(addrs[i], 1'b1, 8'h00);
      total++;
      if (cpu_data_in !== exp[i]) $display("FAIL vec_data addr %h got %h want %h", addrs[i], cpu_data_in, exp[i]);
      else passed++;
      total++;
      if (mem_req !== 1'b0 || cpu_rdy !== 1'b1) $display("FAIL vec_ctrl addr %h req %b rdy %b want 0 1", addrs[i], mem_req, cpu_rdy);
      else passed++;
    end
  endtask

  task automatic test_mem_read();
    issue(16'h1234, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cpu_rdy !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h1234 || mem_we !== 1'b0)
        $display("FAIL rd_wait cyc %0d rdy %b req %b addr %h we %b want 0 1 1234 0", i, cpu_rdy, mem_req, mem_addr, mem_we);
      else passed++;
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
      end
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if (cpu_data_in !== 8'h5A || cpu_rdy !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL rd_done data %h rdy %b req %b want 5A 1 0", cpu_data_in, cpu_rdy, mem_req);
    else passed++;
  endtask

  task automatic test_mem_write();
    issue(16'h0200, 1'b0, 8'hA5);
    total++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'hA5 || mem_addr !== 16'h0200 || mem_req !== 1'b1 || cpu_rdy !== 1'b0)
      $display("FAIL wr_req we %b wdata %h addr %h req %b rdy %b want 1 A5 0200 1 0", mem_we, mem_wdata, mem_addr, mem_req, cpu_rdy);
    else passed++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if (cpu_rdy !== 1'b1 || mem_req !== 1'b0 || cpu_data_in !== 8'h5A)
      $display("FAIL wr_done rdy %b req %b data %h want 1 0 5A", cpu_rdy, mem_req, cpu_data_in);
    else passed++;
    issue(16'hFFFE, 1'b0, 8'h11);
    total++;
    if (mem_req !== 1'b0 || cpu_rdy !== 1'b1 || cpu_data_in !== 8'h5A || bus_error !== 1'b0)
      $display("FAIL vec_write req %b rdy %b data %h err %b want 0 1 5A 0", mem_req, cpu_rdy, cpu_data_in, bus_error);
    else passed++;
  endtask

  task automatic test_timeout();
    issue(16'h3000, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (cpu_rdy !== 1'b0 || bus_error !== 1'b0) $display("FAIL to_wait cyc %0d rdy %b err %b want 0 0", i, cpu_rdy, bus_error);
      else passed++;
    end
    tick();
    total++;
    if (cpu_data_in !== 8'hFF || bus_error !== 1'b1 || cpu_rdy !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL to_abort data %h err %b rdy %b req %b want FF 1 1 0", cpu_data_in, bus_error, cpu_rdy, mem_req);
    else passed++;
    tick();
    total++;
    if (bus_error !== 1'b0) $display("FAIL to_pulse err %b want 0", bus_error);
    else passed++;
  endtask

  task automatic test_ack_at_limit();
    issue(16'h3000, 1'b1, 8'h00);
    tick();
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    total++;
    if (cpu_data_in !== 8'h3C || bus_error !== 1'b0 || cpu_rdy !== 1'b1)
      $display("FAIL ack_limit data %h err %b rdy %b want 3C 0 1", cpu_data_in, bus_error, cpu_rdy);
    else passed++;
    tick();
    total++;
    if (bus_error !== 1'b0) $display("FAIL ack_limit_next err %b want 0", bus_error);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue(16'h0010, 1'b1, 8'h00);
    mem_ack   = 1'b1;
    mem_rdata = 8'h21;
    tick();
    mem_ack = 1'b0;
    issue(16'h0011, 1'b1, 8'h00);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0011 || cpu_data_in !== 8'h21)
      $display("FAIL b2b req %b addr %h data %h want 1 0011 21", mem_req, mem_addr, cpu_data_in);
    else passed++;
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    tick();
    mem_ack = 1'b0;
    total++;
    if (cpu_data_in !== 8'h42 || cpu_rdy !== 1'b1) $display("FAIL b2b_done data %h rdy %b want 42 1", cpu_data_in, cpu_rdy);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    issue(16'h4000, 1'b1, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (mem_req !== 1'b0 || cpu_rdy !== 1'b1 || cpu_data_in !== 8'h00)
      $display("FAIL rst_mid req %b rdy %b data %h want 0 1 00", mem_req, cpu_rdy, cpu_data_in);
    else passed++;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    total++;
    if (cpu_data_in !== 8'h00 || mem_req !== 1'b0 || bus_error !== 1'b0)
      $display("FAIL rst_late_ack data %h req %b err %b want 00 0 0", cpu_data_in, mem_req, bus_error);
    else passed++;
  endtask

  initial begin
    rst           = 1'b0;
    cpu_addr_high = 8'h00;
    cpu_addr_low  = 8'h00;
    cpu_data_out  = 8'h00;
    cpu_rw        = 1'b1;
    cpu_req       = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = 8'h00;
    #2;
    test_reset();
    test_vector_read();
    test_mem_read();
    test_mem_write();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
